cycle_sequencer: RTL and testbench

Instruction-cycle controller for the CPU core. Generates the 8-phase `cycle` count that steps the program counter block through its address-out, memory and execute phases. Owns run/halt/single-step control and decodes jump-class instructions into program-counter write enables and next-value selects. Sits between the instruction fetch path and the program counter block, and is the only driver of that block's `cycle`, `halt`, `pc_next_sel` and `pc_write_enable` inputs.

---
 rtl/cycle_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
//
// Instruction-cycle controller for the CPU core. It produces the 8-phase
// cycle count that walks the program counter block through address-out,
// memory and execute phases. It also owns run/halt/single-step control and
// turns jump-class instructions into program-counter write enables and
// next-value selects.
//
// Ports
//   clock           in  1  sole clock, rising edge
//   reset_n         in  1  synchronous, active-low reset
//   halt_req        in  1  level request to stop at the next instruction boundary
//   step            in  1  one-clock pulse; while halted, runs one instruction
//   data            in  4  memory bus nibble (OPR valid in cycle 3, OPA in cycle 4)
//   cond_true       in  1  jump condition, sampled in cycle 5
//   cycle           out 3  phase count 0..7
//   halt            out 1  freezes the program counter block
//   sync            out 1  high during cycle 7 (instruction boundary)
//   second_word     out 1  current instruction cycle is an operand word
//   pc_next_sel     out 2  PC source select: DATA=0, REG=1, INST=2
//   pc_write_enable out 3  bit0 -> PC[3:0], bit1 -> PC[7:4], bit2 always 0
// ---------------------------------------------------------------------------
module cycle_sequencer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       halt_req,
   input  logic       step,
   input  logic [3:0] data,
   input  logic       cond_true,
   output logic [2:0] cycle,
   output logic       halt,
   output logic       sync,
   output logic       second_word,
   output logic [1:0] pc_next_sel,
   output logic [2:0] pc_write_enable
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      STEP   = 2'd2
   } state_t;

   localparam logic [3:0] OP_JCN = 4'h1;
   localparam logic [3:0] OP_JIN = 4'h3;
   localparam logic [3:0] OP_JUN = 4'h4;
   localparam logic [3:0] OP_BRS = 4'hC;

   localparam logic [1:0] SEL_DATA = 2'd0;
   localparam logic [1:0] SEL_REG  = 2'd1;
   localparam logic [1:0] SEL_INST = 2'd2;

   state_t     state;
   state_t     state_next;
   logic [3:0] opr;
   logic       opa_lsb;
   logic       cond_latch;
   logic       jump_pending;
   logic       second_word_q;
   logic       two_word_first;
   logic       running;

   // Only the low OPA bit affects sequencing (it separates JIN from FIN),
   // so that is the only bit of the operand nibble that is kept.

   // The phase counter advances in every state except HALTED, where it
   // sits at 0 so the PC block sees a clean instruction boundary.
   assign running = (state != HALTED);

   // A first word of JUN/JCN means the next instruction cycle belongs to
   // the same instruction, so a halt must not be taken at this boundary.
   assign two_word_first = !second_word_q && ((opr == OP_JCN) || (opr == OP_JUN));

   assign second_word = second_word_q;

   // State register for the run/halt/step machine.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and all combinational outputs. Outputs depend only on
   // registered state and the cycle count, never directly on the inputs.
   // A dropped halt_req always wins over the end-of-step return to HALTED.
   always_comb begin
      state_next      = state;
      halt            = (state == HALTED);
      sync            = (cycle == 3'd7);
      pc_write_enable = 3'b000;
      pc_next_sel     = SEL_DATA;

      case (state)
         RUN: begin
            if ((cycle == 3'd7) && halt_req && !two_word_first) begin
               state_next = HALTED;
            end
         end
         HALTED: begin
            if (!halt_req) begin
               state_next = RUN;
            end else if (step) begin
               state_next = STEP;
            end
         end
         STEP: begin
            if (!halt_req) begin
               state_next = RUN;
            end else if ((cycle == 3'd7) && !two_word_first) begin
               state_next = HALTED;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase

      // Jump decode. In an operand word the target nibbles arrive on the
      // bus in cycles 3 and 4; JIN takes the register pair in cycles 5/6;
      // BRS reloads only the low nibble from the instruction's own OPA.
      if (second_word_q) begin
         if (jump_pending) begin
            if (cycle == 3'd3) begin
               pc_write_enable = 3'b010;
            end else if (cycle == 3'd4) begin
               pc_write_enable = 3'b001;
            end
         end
      end else if ((opr == OP_JIN) && opa_lsb) begin
         if (cycle == 3'd5) begin
            pc_write_enable = 3'b010;
            pc_next_sel     = SEL_REG;
         end else if (cycle == 3'd6) begin
            pc_write_enable = 3'b001;
            pc_next_sel     = SEL_REG;
         end
      end else if (opr == OP_BRS) begin
         if (cycle == 3'd5) begin
            pc_write_enable = 3'b001;
            pc_next_sel     = SEL_INST;
         end
      end
   end

   // Phase counter and decode latches. The opcode, operand bit and
   // condition are captured only from a first word, so an operand word
   // (which carries address nibbles) never disturbs the decode of the
   // instruction it belongs to. At the boundary a JUN/JCN first word
   // arms the operand word; an operand word always disarms it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cycle         <= 3'd0;
         opr           <= 4'h0;
         opa_lsb       <= 1'b0;
         cond_latch    <= 1'b0;
         jump_pending  <= 1'b0;
         second_word_q <= 1'b0;
      end else if (running) begin
         cycle <= cycle + 3'd1;

         if (!second_word_q) begin
            if (cycle == 3'd3) begin
               opr <= data;
            end
            if (cycle == 3'd4) begin
               opa_lsb <= data[0];
            end
            if (cycle == 3'd5) begin
               cond_latch <= cond_true;
            end
         end

         if (cycle == 3'd7) begin
            if (second_word_q) begin
               second_word_q <= 1'b0;
               jump_pending  <= 1'b0;
            end else if (opr == OP_JUN) begin
               second_word_q <= 1'b1;
               jump_pending  <= 1'b1;
            end else if (opr == OP_JCN) begin
               second_word_q <= 1'b1;
               jump_pending  <= cond_latch;
            end
         end
      end
   end

endmodule

// File: tb/tb_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cycle_sequencer
//
// Self-checking bench for cycle_sequencer. The bench plays the part of the
// memory bus and the program counter block: it puts instruction nibbles on
// data in cycles 3/4, applies the sequencer's write enables to its own PC
// copy, and compares per-cycle outputs against an instruction-level model.
// ---------------------------------------------------------------------------
module tb_cycle_sequencer;

   localparam logic [1:0] SEL_DATA = 2'd0;
   localparam logic [1:0] SEL_REG  = 2'd1;
   localparam logic [1:0] SEL_INST = 2'd2;

   logic       clock;
   logic       reset_n;
   logic       halt_req;
   logic       step;
   logic [3:0] data;
   logic       cond_true;
   logic [2:0] cycle;
   logic       halt;
   logic       sync;
   logic       second_word;
   logic [1:0] pc_next_sel;
   logic [2:0] pc_write_enable;

   int errors = 0;
   int checks = 0;

   // Per-cycle observations of the last word driven.
   logic [2:0] obs_cycle [8];
   logic       obs_halt  [8];
   logic       obs_sync  [8];
   logic       obs_sw    [8];
   logic [2:0] obs_we    [8];
   logic [1:0] obs_sel   [8];

   // Per-cycle expectations from the instruction-level model.
   logic [2:0] exp_we  [8];
   logic [1:0] exp_sel [8];

   // Program counter block stand-in and register pair for JIN.
   logic [7:0] pc_tb;
   logic [3:0] reg_hi;
   logic [3:0] reg_lo;
   logic [3:0] cur_opa;

   cycle_sequencer dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .halt_req        (halt_req),
      .step            (step),
      .data            (data),
      .cond_true       (cond_true),
      .cycle           (cycle),
      .halt            (halt),
      .sync            (sync),
      .second_word     (second_word),
      .pc_next_sel     (pc_next_sel),
      .pc_write_enable (pc_write_enable)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one instruction word starting at a negedge where the DUT is in
   // cycle 0. Outputs are recorded at each negedge, bus inputs are set for
   // that cycle, and the PC copy takes whatever write the DUT requests.
   // Returns at the negedge after the last driven cycle.
   task automatic applyStimulus(input logic [3:0] w3, input logic [3:0] w4,
                                input logic cond, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         obs_cycle[c] = cycle;
         obs_halt[c]  = halt;
         obs_sync[c]  = sync;
         obs_sw[c]    = second_word;
         obs_we[c]    = pc_write_enable;
         obs_sel[c]   = pc_next_sel;
         data      = (c == 3) ? w3 : (c == 4) ? w4 : 4'($urandom);
         cond_true = (c == 5) ? cond : 1'($urandom);
         step      = 1'($urandom);
         if (pc_write_enable[1])
            pc_tb[7:4] = (pc_next_sel == SEL_REG) ? reg_hi : data;
         if (pc_write_enable[0])
            pc_tb[3:0] = (pc_next_sel == SEL_REG) ? reg_lo :
                         (pc_next_sel == SEL_INST) ? cur_opa : data;
         @(negedge clock);
      end
      step = 1'b0;
   endtask

   // Instruction-level expectation table for one word.
   task automatic model_expect(input logic is_second, input logic take,
                               input logic [3:0] opr_v, input logic [3:0] opa_v);
      for (int c = 0; c < 8; c++) begin
         exp_we[c]  = 3'b000;
         exp_sel[c] = SEL_DATA;
      end
      if (is_second) begin
         if (take) begin
            exp_we[3] = 3'b010;
            exp_we[4] = 3'b001;
         end
      end else if (opr_v == 4'h3 && opa_v[0]) begin
         exp_we[5] = 3'b010; exp_sel[5] = SEL_REG;
         exp_we[6] = 3'b001; exp_sel[6] = SEL_REG;
      end else if (opr_v == 4'hC) begin
         exp_we[5] = 3'b001; exp_sel[5] = SEL_INST;
      end
   endtask

   // Reset held for two clocks; outputs must sit at their reset values.
   task automatic test_reset();
      reset_n = 1'b0; halt_req = 1'b0; step = 1'b0; data = 4'h0; cond_true = 1'b0;
      pc_tb = 8'h00; reg_hi = 4'h0; reg_lo = 4'h0; cur_opa = 4'h0;
      @(negedge clock);
      @(negedge clock);
      checks++; if (cycle !== 3'd0) begin errors++; $display("[TB] FAIL reset_cycle: got %0d expected 0", cycle); end
      checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
      checks++; if (sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync: got %b expected 0", sync); end
      checks++; if (second_word !== 1'b0) begin errors++; $display("[TB] FAIL reset_second_word: got %b expected 0", second_word); end
      checks++; if (pc_write_enable !== 3'b000) begin errors++; $display("[TB] FAIL reset_we: got %b expected 000", pc_write_enable); end
      checks++; if (pc_next_sel !== SEL_DATA) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", pc_next_sel); end
      reset_n = 1'b1;
   endtask

   // Two plain words: cycle must count 0..7 twice with sync only in 7.
   task automatic test_free_run();
      for (int w = 0; w < 2; w++) begin
         applyStimulus(4'h2, 4'($urandom), 1'b0, 8);
         for (int c = 0; c < 8; c++) begin
            checks++; if (obs_cycle[c] !== 3'(c)) begin errors++; $display("[TB] FAIL free_cycle: got %0d expected %0d", obs_cycle[c], c); end
            checks++; if (obs_sync[c] !== (c == 7)) begin errors++; $display("[TB] FAIL free_sync c%0d: got %b expected %b", c, obs_sync[c], (c == 7)); end
            checks++; if (obs_we[c] !== 3'b000) begin errors++; $display("[TB] FAIL free_we c%0d: got %b expected 000", c, obs_we[c]); end
         end
      end
   endtask

   // JUN to A5: operand word writes high nibble in cycle 3, low in cycle 4.
   task automatic test_jun();
      cur_opa = 4'h0;
      applyStimulus(4'h4, 4'h0, 1'($urandom), 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_we[c] !== 3'b000) begin errors++; $display("[TB] FAIL jun_first_we c%0d: got %b expected 000", c, obs_we[c]); end
      end
      applyStimulus(4'hA, 4'h5, 1'b0, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_sw[c] !== 1'b1) begin errors++; $display("[TB] FAIL jun_second_word c%0d: got %b expected 1", c, obs_sw[c]); end
      end
      checks++; if (obs_we[3] !== 3'b010 || obs_sel[3] !== SEL_DATA) begin errors++; $display("[TB] FAIL jun_c3: got we=%b sel=%0d expected we=010 sel=0", obs_we[3], obs_sel[3]); end
      checks++; if (obs_we[4] !== 3'b001 || obs_sel[4] !== SEL_DATA) begin errors++; $display("[TB] FAIL jun_c4: got we=%b sel=%0d expected we=001 sel=0", obs_we[4], obs_sel[4]); end
      checks++; if (pc_tb !== 8'hA5) begin errors++; $display("[TB] FAIL jun_pc: got %h expected a5", pc_tb); end
      checks++; if (second_word !== 1'b0) begin errors++; $display("[TB] FAIL jun_sw_clear: got %b expected 0", second_word); end
   endtask

   // JCN not taken: operand word fetched and discarded. Then taken.
   task automatic test_jcn();
      logic [7:0] pc_before;
      cur_opa = 4'h6;
      applyStimulus(4'h1, 4'h6, 1'b0, 8);
      pc_before = pc_tb;
      applyStimulus(4'h9, 4'h9, 1'b1, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_sw[c] !== 1'b1) begin errors++; $display("[TB] FAIL jcn0_second_word c%0d: got %b expected 1", c, obs_sw[c]); end
         checks++; if (obs_we[c] !== 3'b000) begin errors++; $display("[TB] FAIL jcn0_we c%0d: got %b expected 000", c, obs_we[c]); end
      end
      checks++; if (pc_tb !== pc_before) begin errors++; $display("[TB] FAIL jcn0_pc: got %h expected %h", pc_tb, pc_before); end
      applyStimulus(4'h1, 4'h2, 1'b1, 8);
      applyStimulus(4'h3, 4'hC, 1'b0, 8);
      checks++; if (obs_we[3] !== 3'b010 || obs_sel[3] !== SEL_DATA) begin errors++; $display("[TB] FAIL jcn1_c3: got we=%b sel=%0d expected we=010 sel=0", obs_we[3], obs_sel[3]); end
      checks++; if (obs_we[4] !== 3'b001 || obs_sel[4] !== SEL_DATA) begin errors++; $display("[TB] FAIL jcn1_c4: got we=%b sel=%0d expected we=001 sel=0", obs_we[4], obs_sel[4]); end
      checks++; if (pc_tb !== 8'h3C) begin errors++; $display("[TB] FAIL jcn1_pc: got %h expected 3c", pc_tb); end
   endtask

   // JIN pulls the register pair; JIN with opa[0]=0 does nothing; BRS
   // reloads the low nibble from OPA.
   task automatic test_jin_brs();
      reg_hi = 4'h9; reg_lo = 4'h6; cur_opa = 4'h1;
      applyStimulus(4'h3, 4'h1, 1'b0, 8);
      checks++; if (obs_we[5] !== 3'b010 || obs_sel[5] !== SEL_REG) begin errors++; $display("[TB] FAIL jin_c5: got we=%b sel=%0d expected we=010 sel=1", obs_we[5], obs_sel[5]); end
      checks++; if (obs_we[6] !== 3'b001 || obs_sel[6] !== SEL_REG) begin errors++; $display("[TB] FAIL jin_c6: got we=%b sel=%0d expected we=001 sel=1", obs_we[6], obs_sel[6]); end
      checks++; if (pc_tb !== 8'h96) begin errors++; $display("[TB] FAIL jin_pc: got %h expected 96", pc_tb); end
      cur_opa = 4'h0;
      applyStimulus(4'h3, 4'h0, 1'b0, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_we[c] !== 3'b000) begin errors++; $display("[TB] FAIL fin_we c%0d: got %b expected 000", c, obs_we[c]); end
      end
      cur_opa = 4'h7;
      applyStimulus(4'hC, 4'h7, 1'b0, 8);
      checks++; if (obs_we[5] !== 3'b001 || obs_sel[5] !== SEL_INST) begin errors++; $display("[TB] FAIL brs_c5: got we=%b sel=%0d expected we=001 sel=2", obs_we[5], obs_sel[5]); end
      checks++; if (pc_tb !== 8'h97) begin errors++; $display("[TB] FAIL brs_pc: got %h expected 97", pc_tb); end
   endtask

   // Random instruction stream against the instruction-level model.
   task automatic test_random_mix();
      logic       m_second = 1'b0;
      logic       m_take   = 1'b0;
      logic [3:0] w3, w4;
      logic       cond;
      logic [7:0] exp_pc;
      int         i = 0;
      while (i < 40 || m_second) begin
         w3 = 4'($urandom); w4 = 4'($urandom); cond = 1'($urandom);
         reg_hi = 4'($urandom); reg_lo = 4'($urandom);
         if (!m_second) begin
            case ($urandom_range(0, 5))
               0: w3 = 4'h1;
               1: w3 = 4'h4;
               2: w3 = 4'h3;
               3: w3 = 4'hC;
               default: ;
            endcase
            cur_opa = w4;
         end
         exp_pc = pc_tb;
         if (m_second) begin
            if (m_take) exp_pc = {w3, w4};
         end else if (w3 == 4'h3 && w4[0]) begin
            exp_pc = {reg_hi, reg_lo};
         end else if (w3 == 4'hC) begin
            exp_pc = {pc_tb[7:4], w4};
         end
         model_expect(m_second, m_take, w3, w4);
         applyStimulus(w3, w4, cond, 8);
         for (int c = 0; c < 8; c++) begin
            checks++; if (obs_cycle[c] !== 3'(c)) begin errors++; $display("[TB] FAIL mix_cycle w%0d: got %0d expected %0d", i, obs_cycle[c], c); end
            checks++; if (obs_halt[c] !== 1'b0) begin errors++; $display("[TB] FAIL mix_halt w%0d c%0d: got %b expected 0", i, c, obs_halt[c]); end
            checks++; if (obs_sw[c] !== m_second) begin errors++; $display("[TB] FAIL mix_second_word w%0d c%0d: got %b expected %b", i, c, obs_sw[c], m_second); end
            checks++; if (obs_we[c] !== exp_we[c]) begin errors++; $display("[TB] FAIL mix_we w%0d c%0d: got %b expected %b", i, c, obs_we[c], exp_we[c]); end
            checks++; if (obs_sel[c] !== exp_sel[c]) begin errors++; $display("[TB] FAIL mix_sel w%0d c%0d: got %0d expected %0d", i, c, obs_sel[c], exp_sel[c]); end
         end
         checks++; if (pc_tb !== exp_pc) begin errors++; $display("[TB] FAIL mix_pc w%0d: got %h expected %h", i, pc_tb, exp_pc); end
         if (m_second) begin
            m_second = 1'b0;
         end else if (w3 == 4'h1 || w3 == 4'h4) begin
            m_second = 1'b1;
            m_take   = (w3 == 4'h4) ? 1'b1 : cond;
         end
         i++;
      end
   endtask

   // halt_req raised in a JUN first word: runs the operand word, then halts.
   task automatic test_halt_two_word();
      halt_req = 1'b1;
      applyStimulus(4'h4, 4'h0, 1'b0, 8);
      applyStimulus(4'hB, 4'h2, 1'b0, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_halt[c] !== 1'b0) begin errors++; $display("[TB] FAIL halt2w_halt c%0d: got %b expected 0", c, obs_halt[c]); end
         checks++; if (obs_sw[c] !== 1'b1) begin errors++; $display("[TB] FAIL halt2w_sw c%0d: got %b expected 1", c, obs_sw[c]); end
      end
      checks++; if (pc_tb !== 8'hB2) begin errors++; $display("[TB] FAIL halt2w_pc: got %h expected b2", pc_tb); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halted_halt k%0d: got %b expected 1", k, halt); end
         checks++; if (cycle !== 3'd0) begin errors++; $display("[TB] FAIL halted_cycle k%0d: got %0d expected 0", k, cycle); end
         checks++; if (pc_write_enable !== 3'b000) begin errors++; $display("[TB] FAIL halted_we k%0d: got %b expected 000", k, pc_write_enable); end
         @(negedge clock);
      end
   endtask

   // One step pulse while halted runs exactly cycles 0..7 then halts again.
   task automatic test_step();
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      applyStimulus(4'h2, 4'h0, 1'b0, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_cycle[c] !== 3'(c)) begin errors++; $display("[TB] FAIL step_cycle: got %0d expected %0d", obs_cycle[c], c); end
         checks++; if (obs_halt[c] !== 1'b0) begin errors++; $display("[TB] FAIL step_halt c%0d: got %b expected 0", c, obs_halt[c]); end
      end
      checks++; if (halt !== 1'b1 || cycle !== 3'd0) begin errors++; $display("[TB] FAIL step_end: got halt=%b cycle=%0d expected halt=1 cycle=0", halt, cycle); end
      @(negedge clock);
      checks++; if (halt !== 1'b1 || cycle !== 3'd0) begin errors++; $display("[TB] FAIL step_hold: got halt=%b cycle=%0d expected halt=1 cycle=0", halt, cycle); end
   endtask

   // halt_req drop: halt clears one clock later with cycle still 0.
   task automatic test_resume();
      halt_req = 1'b0;
      @(negedge clock);
      checks++; if (halt !== 1'b0 || cycle !== 3'd0) begin errors++; $display("[TB] FAIL resume: got halt=%b cycle=%0d expected halt=0 cycle=0", halt, cycle); end
      applyStimulus(4'h2, 4'h0, 1'b0, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_cycle[c] !== 3'(c)) begin errors++; $display("[TB] FAIL resume_cycle: got %0d expected %0d", obs_cycle[c], c); end
      end
   endtask

   // Reset in the middle of a stepped JUN operand word abandons it.
   task automatic test_reset_mid_step();
      halt_req = 1'b1;
      applyStimulus(4'h2, 4'h0, 1'b0, 8);
      checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL rms_halted: got %b expected 1", halt); end
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      applyStimulus(4'h4, 4'h0, 1'b0, 8);
      applyStimulus(4'hE, 4'h1, 1'b0, 4);
      checks++; if (cycle !== 3'd4 || second_word !== 1'b1 || pc_write_enable !== 3'b001) begin
         errors++; $display("[TB] FAIL rms_mid: got cycle=%0d sw=%b we=%b expected cycle=4 sw=1 we=001", cycle, second_word, pc_write_enable); end
      reset_n = 1'b0; halt_req = 1'b0;
      @(negedge clock);
      checks++; if (cycle !== 3'd0) begin errors++; $display("[TB] FAIL rms_cycle: got %0d expected 0", cycle); end
      checks++; if (halt !== 1'b0 || sync !== 1'b0) begin errors++; $display("[TB] FAIL rms_halt_sync: got halt=%b sync=%b expected 0 0", halt, sync); end
      checks++; if (second_word !== 1'b0) begin errors++; $display("[TB] FAIL rms_sw: got %b expected 0", second_word); end
      checks++; if (pc_write_enable !== 3'b000 || pc_next_sel !== SEL_DATA) begin errors++; $display("[TB] FAIL rms_we_sel: got we=%b sel=%0d expected 000 0", pc_write_enable, pc_next_sel); end
      reset_n = 1'b1;
      applyStimulus(4'h2, 4'h0, 1'b0, 8);
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_sw[c] !== 1'b0 || obs_we[c] !== 3'b000) begin errors++; $display("[TB] FAIL rms_after c%0d: got sw=%b we=%b expected 0 000", c, obs_sw[c], obs_we[c]); end
         checks++; if (obs_cycle[c] !== 3'(c)) begin errors++; $display("[TB] FAIL rms_after_cycle: got %0d expected %0d", obs_cycle[c], c); end
      end
   endtask

   // Top-level sequence; each test leaves the DUT at a word boundary.
   initial begin
      test_reset();
      test_free_run();
      test_jun();
      test_jcn();
      test_jin_brs();
      test_random_mix();
      test_halt_two_word();
      test_step();
      test_resume();
      test_reset_mid_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
